// File: rtl/a2d_if.sv
// Bundles the SPI-master handshake and the on-demand request channel
// shared between the A2D scheduler and its environment.
interface a2d_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic        req;
    logic [2:0]  req_ch;
    logic        gnt;
    logic [11:0] req_data;
    logic        req_vld;

    modport master (
        output wrt, cmd, gnt, req_data, req_vld,
        input  done, resp, req, req_ch
    );

    modport slave (
        input  wrt, cmd, gnt, req_data, req_vld,
        output done, resp, req, req_ch
    );
endinterface

// File: rtl/a2d_scheduler.sv
// A2D conversion scheduler: runs a periodic round over channels 0,1,3,4
// on a free-running interval timer and interleaves on-demand conversions
// through a shared SPI master, one two-transaction conversion at a time.
module a2d_scheduler #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    a2d_if.master       bus,
    output logic [11:0] o_batt,
    output logic [11:0] o_curr,
    output logic [11:0] o_brake,
    output logic [11:0] o_torque,
    output logic        o_rnd_vld
);

    localparam logic [13:0] TMR_LAST = FAST_SIM ? 14'd1023 : 14'd16383;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WAIT1 = 3'd2,
        S_GAP   = 3'd3,
        S_READ  = 3'd4,
        S_WAIT2 = 3'd5,
        S_STORE = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [13:0] r_timer;
    logic        r_pend;      // a round is waiting to start
    logic        r_in_round;  // a round has started and not yet finished
    logic [1:0]  r_idx;       // next round slot to convert
    logic        r_last_od;   // previous conversion was on-demand
    logic        r_is_od;     // conversion in flight is on-demand

    logic        r_wrt;
    logic [15:0] r_cmd;
    logic        r_gnt;
    logic [11:0] r_req_data;
    logic        r_req_vld;
    logic [11:0] r_batt;
    logic [11:0] r_curr;
    logic [11:0] r_brake;
    logic [11:0] r_torque;
    logic        r_rnd_vld;

    logic        w_wrap;
    logic        w_per_avail;
    logic        w_pick_od;
    logic        w_pick_per;
    logic        w_launch;
    logic        w_round_start;
    logic        w_store;
    logic [2:0]  w_launch_ch;
    logic        w_wrt_nxt;
    logic        w_unused_resp;

    // Round slot to physical channel number.
    function automatic logic [2:0] f_round_ch(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = 3'd0;
            2'd1:    ch = 3'd1;
            2'd2:    ch = 3'd3;
            2'd3:    ch = 3'd4;
            default: ch = 3'd0;
        endcase
        return ch;
    endfunction

    assign w_wrap        = (r_timer == TMR_LAST);
    assign w_per_avail   = r_pend | r_in_round;
    // On-demand wins unless it also won last time while periodic work waits.
    assign w_pick_od     = bus.req & ~(r_last_od & w_per_avail);
    assign w_pick_per    = ~w_pick_od & w_per_avail;
    assign w_launch      = (r_state == S_IDLE) & (w_pick_od | w_pick_per);
    assign w_round_start = w_launch & w_pick_per & ~r_in_round;
    assign w_store       = (r_state == S_WAIT2) & bus.done;
    assign w_launch_ch   = w_pick_od ? bus.req_ch : f_round_ch(r_idx);
    assign w_unused_resp = ^bus.resp[15:12];

    // Next-state decode and next value of the wrt strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_wrt_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_CMD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CMD:   w_state_nxt = S_WAIT1;
            S_WAIT1: begin
                if (bus.done) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_state_nxt = S_WAIT1;
                end
            end
            S_GAP:   w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_WAIT2;
            S_WAIT2: begin
                if (bus.done) begin
                    w_state_nxt = S_STORE;
                end else begin
                    w_state_nxt = S_WAIT2;
                end
            end
            S_STORE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_wrt_nxt = (w_state_nxt == S_CMD) | (w_state_nxt == S_READ);
    end

    // Conversion state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Interval timer and single-entry pending-round flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 14'd0;
            r_pend  <= 1'b0;
        end else begin
            r_timer <= w_wrap ? 14'd0 : (r_timer + 14'd1);
            if (w_wrap) begin
                r_pend <= 1'b1;
            end else if (w_round_start) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Round progress and arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_round <= 1'b0;
            r_idx      <= 2'd0;
            r_last_od  <= 1'b0;
            r_is_od    <= 1'b0;
        end else if (w_launch) begin
            r_is_od   <= w_pick_od;
            r_last_od <= w_pick_od;
            if (w_round_start) begin
                r_in_round <= 1'b1;
            end
        end else if (w_store && !r_is_od) begin
            if (r_idx == 2'd3) begin
                r_idx      <= 2'd0;
                r_in_round <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // SPI command, write strobe and grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrt <= 1'b0;
            r_cmd <= 16'h0000;
            r_gnt <= 1'b0;
        end else begin
            r_wrt <= w_wrt_nxt;
            r_gnt <= w_launch & w_pick_od;
            if (w_launch) begin
                r_cmd <= {2'b00, w_launch_ch, 11'h000};
            end
        end
    end

    // Result capture on the second done; visible during STORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batt     <= 12'h000;
            r_curr     <= 12'h000;
            r_brake    <= 12'h000;
            r_torque   <= 12'h000;
            r_rnd_vld  <= 1'b0;
            r_req_data <= 12'h000;
            r_req_vld  <= 1'b0;
        end else begin
            r_rnd_vld <= 1'b0;
            r_req_vld <= 1'b0;
            if (w_store) begin
                if (r_is_od) begin
                    r_req_data <= bus.resp[11:0];
                    r_req_vld  <= 1'b1;
                end else begin
                    case (r_idx)
                        2'd0: r_batt  <= bus.resp[11:0];
                        2'd1: r_curr  <= bus.resp[11:0];
                        2'd2: r_brake <= bus.resp[11:0];
                        2'd3: begin
                            r_torque  <= bus.resp[11:0];
                            r_rnd_vld <= 1'b1;
                        end
                        default: r_batt <= r_batt;
                    endcase
                end
            end
        end
    end

    assign bus.wrt      = r_wrt;
    assign bus.cmd      = r_cmd;
    assign bus.gnt      = r_gnt;
    assign bus.req_data = r_req_data;
    assign bus.req_vld  = r_req_vld;
    assign o_batt       = r_batt;
    assign o_curr       = r_curr;
    assign o_brake      = r_brake;
    assign o_torque     = r_torque;
    assign o_rnd_vld    = r_rnd_vld;

endmodule

// File: tb/tb_a2d_scheduler.sv
// Scoreboard bench for a2d_scheduler: stimulus pushes expected SPI commands,
// grants, on-demand results and round results into queues; a monitor pops
// and compares whenever the DUT presents the matching strobe.
module tb_a2d_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    a2d_if       bus();
    logic [11:0] o_batt, o_curr, o_brake, o_torque;
    logic        o_rnd_vld;

    a2d_scheduler #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .o_batt   (o_batt),
        .o_curr   (o_curr),
        .o_brake  (o_brake),
        .o_torque (o_torque),
        .o_rnd_vld(o_rnd_vld)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] RND_EXP = 48'hABC_123_800_700;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_cmd[$];
    logic [15:0] q_gnt[$];
    logic [11:0] q_req[$];
    logic [47:0] q_rnd[$];
    int          n_wrt = 0;
    int          n_rnd = 0;

    int          spi_lat  = 0;
    logic        inj_done = 1'b0;
    logic        spi_busy = 1'b0;
    int          spi_cnt  = 0;
    logic [2:0]  spi_ch   = 3'd0;
    logic        spi_ovl  = 1'b0;

    function automatic logic [11:0] spi_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return 12'hABC;
            3'd1:    return 12'h123;
            3'd2:    return 12'h456;
            3'd3:    return 12'h800;
            3'd4:    return 12'h700;
            3'd5:    return 12'h555;
            default: return 12'h0F0;
        endcase
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [47:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h with no expected entry", name, act);
    endtask

    task automatic push_round();
        q_cmd.push_back(16'h0000); q_cmd.push_back(16'h0000);
        q_cmd.push_back(16'h0800); q_cmd.push_back(16'h0800);
        q_cmd.push_back(16'h1800); q_cmd.push_back(16'h1800);
        q_cmd.push_back(16'h2000); q_cmd.push_back(16'h2000);
        q_rnd.push_back(RND_EXP);
    endtask

    // kind 0: wrt with given cmd, 1: rnd_vld, 2: gnt. cyc = negedges waited.
    task automatic wait_evt(input int kind, input logic [15:0] c, input int budget,
                            input string name, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (kind)
                0:       hit = (bus.wrt === 1'b1) && (bus.cmd === c);
                1:       hit = (o_rnd_vld === 1'b1);
                default: hit = (bus.gnt === 1'b1);
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wrt"},      bus.wrt,      48'd0);
        check({tag, "_cmd"},      bus.cmd,      48'd0);
        check({tag, "_gnt"},      bus.gnt,      48'd0);
        check({tag, "_req_vld"},  bus.req_vld,  48'd0);
        check({tag, "_req_data"}, bus.req_data, 48'd0);
        check({tag, "_rnd_vld"},  o_rnd_vld,    48'd0);
        check({tag, "_results"},  {o_batt, o_curr, o_brake, o_torque}, 48'd0);
    endtask

    // SPI master model: done follows each wrt after spi_lat idle cycles.
    initial begin
        bus.done = 1'b0;
        bus.resp = 16'h0000;
        forever begin
            @(negedge clk);
            bus.done = 1'b0;
            if (spi_busy) begin
                if (bus.wrt === 1'b1) spi_ovl = 1'b1;
                if (spi_cnt == 0) begin
                    bus.done = 1'b1;
                    bus.resp = {4'hE, spi_val(spi_ch)};
                    spi_busy = 1'b0;
                    check("wrt_overlap", spi_ovl, 48'd0);
                    spi_ovl = 1'b0;
                end else begin
                    spi_cnt--;
                end
            end else if (inj_done) begin
                bus.done = 1'b1;
                bus.resp = 16'hEFFF;
                inj_done = 1'b0;
            end else if (bus.wrt === 1'b1 && rst_n === 1'b1) begin
                spi_busy = 1'b1;
                spi_cnt  = spi_lat;
                spi_ch   = bus.cmd[13:11];
            end
        end
    end

    // Monitor: pop and compare on every DUT strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.wrt === 1'b1) begin
                    n_wrt++;
                    if (q_cmd.size() == 0) unexpected("wrt_cmd", bus.cmd);
                    else check("wrt_cmd", bus.cmd, q_cmd.pop_front());
                end
                if (bus.gnt === 1'b1) begin
                    if (q_gnt.size() == 0) unexpected("gnt_cmd", bus.cmd);
                    else check("gnt_cmd", bus.cmd, q_gnt.pop_front());
                end
                if (bus.req_vld === 1'b1) begin
                    if (q_req.size() == 0) unexpected("req_data", bus.req_data);
                    else check("req_data", bus.req_data, q_req.pop_front());
                end
                if (o_rnd_vld === 1'b1) begin
                    n_rnd++;
                    if (q_rnd.size() == 0) unexpected("rnd_results", {o_batt, o_curr, o_brake, o_torque});
                    else check("rnd_results", {o_batt, o_curr, o_brake, o_torque}, q_rnd.pop_front());
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int cyc;
        int w0;
        int base;
        bus.req    = 1'b0;
        bus.req_ch = 3'd0;
        rst_n      = 1'b1;
        #2;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");

        // First round after release: timing, order and results.
        push_round();
        @(negedge clk);
        rst_n = 1'b1;
        wait_evt(0, 16'h0000, 2000, "first_wrt", cyc);
        check("first_wrt_latency", cyc, 48'd1025);
        wait_evt(1, 16'h0000, 200, "round1", cyc);
        check("round1_latency", cyc, 48'd26);

        // On-demand request raised during ch1's first wait.
        spi_lat = 3;
        q_cmd.push_back(16'h0000); q_cmd.push_back(16'h0000);
        q_cmd.push_back(16'h0800); q_cmd.push_back(16'h0800);
        q_cmd.push_back(16'h1000); q_cmd.push_back(16'h1000);
        q_cmd.push_back(16'h1800); q_cmd.push_back(16'h1800);
        q_cmd.push_back(16'h2000); q_cmd.push_back(16'h2000);
        q_gnt.push_back(16'h1000);
        q_req.push_back(12'h456);
        q_rnd.push_back(RND_EXP);
        wait_evt(0, 16'h0800, 2000, "ch1_cmd", cyc);
        #1;
        bus.req    = 1'b1;
        bus.req_ch = 3'd2;
        wait_evt(2, 16'h0000, 200, "gnt_ch2", cyc);
        #1;
        bus.req = 1'b0;
        wait_evt(1, 16'h0000, 300, "round2", cyc);

        // req held through a round: on-demand and periodic alternate.
        spi_lat = 0;
        q_cmd.push_back(16'h0000); q_cmd.push_back(16'h0000);
        q_cmd.push_back(16'h2800); q_cmd.push_back(16'h2800);
        q_cmd.push_back(16'h0800); q_cmd.push_back(16'h0800);
        q_cmd.push_back(16'h2800); q_cmd.push_back(16'h2800);
        q_cmd.push_back(16'h1800); q_cmd.push_back(16'h1800);
        q_cmd.push_back(16'h2800); q_cmd.push_back(16'h2800);
        q_cmd.push_back(16'h2000); q_cmd.push_back(16'h2000);
        for (int i = 0; i < 3; i++) begin
            q_gnt.push_back(16'h2800);
            q_req.push_back(12'h555);
        end
        q_rnd.push_back(RND_EXP);
        wait_evt(0, 16'h0000, 2000, "round3_start", cyc);
        #1;
        w0         = n_wrt;
        bus.req    = 1'b1;
        bus.req_ch = 3'd5;
        wait_evt(1, 16'h0000, 300, "round3", cyc);
        #1;
        bus.req = 1'b0;
        check("alternate_wrt_count", n_wrt - w0, 48'd13);

        // Stalled round spanning three wraps: exactly one extra round.
        base    = n_rnd;
        spi_lat = 300;
        push_round();
        push_round();
        wait_evt(1, 16'h0000, 5000, "stalled_round", cyc);
        spi_lat = 0;
        repeat (400) @(negedge clk);
        #1;
        check("extra_round_count", n_rnd - base, 48'd2);

        // Reset during ch3's second wait.
        spi_lat = 5;
        q_cmd.push_back(16'h0000); q_cmd.push_back(16'h0000);
        q_cmd.push_back(16'h0800); q_cmd.push_back(16'h0800);
        q_cmd.push_back(16'h1800); q_cmd.push_back(16'h1800);
        wait_evt(0, 16'h1800, 4000, "ch3_cmd", cyc);
        wait_evt(0, 16'h1800, 100, "ch3_read", cyc);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        check("midreset_cmd_queue", q_cmd.size(), 48'd0);
        repeat (8) @(negedge clk);
        push_round();
        rst_n = 1'b1;
        wait_evt(0, 16'h0000, 2000, "post_reset_wrt", cyc);
        check("post_reset_latency", cyc, 48'd1025);
        check("post_reset_no_store", {o_batt, o_curr, o_brake, o_torque}, 48'd0);
        check("post_reset_req_data", bus.req_data, 48'd0);
        wait_evt(1, 16'h0000, 300, "post_reset_round", cyc);

        // Spurious done while idle.
        repeat (5) @(negedge clk);
        #1;
        w0       = n_wrt;
        base     = n_rnd;
        inj_done = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("spurious_wrt", n_wrt - w0, 48'd0);
        check("spurious_rnd", n_rnd - base, 48'd0);
        check("spurious_results", {o_batt, o_curr, o_brake, o_torque}, RND_EXP);
        check("spurious_req_data", bus.req_data, 48'd0);

        check("end_cmd_queue", q_cmd.size(), 48'd0);
        check("end_gnt_queue", q_gnt.size(), 48'd0);
        check("end_req_queue", q_req.size(), 48'd0);
        check("end_rnd_queue", q_rnd.size(), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
